// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared definitions for the round-robin SDRAM bank arbiter: FSM state encoding
// and the legal range of requester counts.
package jtframe_sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } arb_state_e;

  localparam int unsigned NREQ_MIN = 2;
  localparam int unsigned NREQ_MAX = 8;

  function automatic bit nreq_ok(input int unsigned n);
    return (n >= NREQ_MIN) && (n <= NREQ_MAX);
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational winner selection: fixed priority among masked high-priority
// requests, otherwise round-robin starting at ptr and wrapping to index 0.
module jtframe_rr_pick
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
)(
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] hiprio,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  function automatic logic [IW-1:0] lowest(input logic [NREQ-1:0] v);
    logic [IW-1:0] r;
    logic          found;
    r     = {IW{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      r     = (!found && v[i]) ? IW'(i) : r;
      found = found | v[i];
    end
    return r;
  endfunction

  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] at_or_after;
  logic [NREQ-1:0] rr_cand;

  // requests at or above ptr go first; if none, the wrap-around is the lowest request overall
  always_comb begin
    at_or_after = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      at_or_after[i] = (IW'(i) >= ptr);
    end
    hi      = req & hiprio;
    rr_cand = req & at_or_after;
    valid   = |req;
    if (|hi) begin
      idx = lowest(hi);
    end else if (|rr_cand) begin
      idx = lowest(rr_cand);
    end else begin
      idx = lowest(req);
    end
    onehot = valid ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : {NREQ{1'b0}};
  end

endmodule

// File: rtl/jtframe_sdram_rrarb.sv
// Round-robin arbiter sharing one SDRAM bank port among NREQ requesters, one
// transaction in flight. Optional watchdog enabled by JTFRAME_ARB_TIMEOUT_EN.
module jtframe_sdram_rrarb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int unsigned     SDRAMW  = 22,
  parameter int unsigned     NREQ    = 4,
  parameter logic [NREQ-1:0] HIPRIO  = {NREQ{1'b0}},
  parameter int unsigned     TIMEOUT = 255
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*SDRAMW-1:0] req_addr,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*16-1:0]     req_din,
  input  logic [NREQ*2-1:0]      req_wrmask,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rdy,
  output logic [31:0]            dout,
  output logic                   sdram_req,
  input  logic                   sdram_ack,
  output logic [SDRAMW-1:0]      sdram_addr,
  output logic                   sdram_rnw,
  output logic [15:0]            sdram_din,
  output logic [1:0]             sdram_wrmask,
  input  logic                   data_rdy,
  input  logic [31:0]            data_read,
  output logic                   timeout
);

  localparam int unsigned IW = $clog2(NREQ);

  if (!nreq_ok(NREQ)) begin : g_nreq_bad
    $error("jtframe_sdram_rrarb: NREQ must be within 2..8");
  end

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, rdy_q, rdy_d;
  logic [31:0]       dout_q, dout_d;
  logic              sdram_req_q, sdram_req_d, rnw_q, rnw_d, timeout_q, timeout_d;
  logic [SDRAMW-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [1:0]        mask_q, mask_d;
  logic [IW-1:0]     idx_q, idx_d, ptr_q, ptr_d;

  logic [SDRAMW-1:0] addr_a [NREQ];
  logic [15:0]       din_a  [NREQ];
  logic [1:0]        mask_a [NREQ];
  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid, tmo_fire, done;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*SDRAMW +: SDRAMW];
    assign din_a[g]  = req_din[g*16 +: 16];
    assign mask_a[g] = req_wrmask[g*2 +: 2];
  end

  // the requester being answered this cycle must not win again immediately
  jtframe_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req & ~rdy_q),
    .hiprio (HIPRIO),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef JTFRAME_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // watchdog only runs while waiting for data, so it restarts at every ack
  always_comb begin
    if (state_q == ST_WAIT_RDY) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo_fire = (state_q == ST_WAIT_RDY) && (cnt_q == CW'(TIMEOUT - 1));
`else
  assign tmo_fire = 1'b0;
`endif

  // a same-cycle ack and data_rdy counts as ack followed by completion
  assign done = ((state_q == ST_WAIT_ACK) && sdram_ack && data_rdy) ||
                ((state_q == ST_WAIT_RDY) && (data_rdy || tmo_fire));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = pick_valid ? ST_WAIT_ACK : ST_IDLE;
      ST_WAIT_ACK: state_d = sdram_ack ? (data_rdy ? ST_IDLE : ST_WAIT_RDY) : ST_WAIT_ACK;
      ST_WAIT_RDY: state_d = done ? ST_IDLE : ST_WAIT_RDY;
      default:     state_d = ST_IDLE;
    endcase
  end

  // grant capture, controller request and completion outputs
  always_comb begin
    gnt_d       = gnt_q;
    rdy_d       = {NREQ{1'b0}};
    dout_d      = dout_q;
    sdram_req_d = sdram_req_q;
    addr_d      = addr_q;
    rnw_d       = rnw_q;
    din_d       = din_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    timeout_d   = timeout_q | (tmo_fire & ~data_rdy);
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d       = pick_onehot;
          idx_d       = pick_idx;
          addr_d      = addr_a[pick_idx];
          rnw_d       = ~req_wr[pick_idx];
          din_d       = din_a[pick_idx];
          mask_d      = mask_a[pick_idx];
          sdram_req_d = 1'b1;
        end else begin
          sdram_req_d = 1'b0;
        end
      end
      ST_WAIT_ACK: sdram_req_d = ~sdram_ack;
      ST_WAIT_RDY: sdram_req_d = 1'b0;
      default: begin
        gnt_d       = {NREQ{1'b0}};
        sdram_req_d = 1'b0;
      end
    endcase
    if (done) begin
      dout_d = data_rdy ? data_read : 32'd0;
      rdy_d  = gnt_q;
      gnt_d  = {NREQ{1'b0}};
      ptr_d  = (idx_q == IW'(NREQ - 1)) ? {IW{1'b0}} : idx_q + IW'(1);
    end else begin
      rdy_d  = {NREQ{1'b0}};
    end
  end

  // output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= {NREQ{1'b0}};
      rdy_q       <= {NREQ{1'b0}};
      dout_q      <= 32'd0;
      sdram_req_q <= 1'b0;
      addr_q      <= {SDRAMW{1'b0}};
      rnw_q       <= 1'b0;
      din_q       <= 16'd0;
      mask_q      <= 2'd0;
      idx_q       <= {IW{1'b0}};
      ptr_q       <= {IW{1'b0}};
      timeout_q   <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      rdy_q       <= rdy_d;
      dout_q      <= dout_d;
      sdram_req_q <= sdram_req_d;
      addr_q      <= addr_d;
      rnw_q       <= rnw_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt          = gnt_q;
  assign rdy          = rdy_q;
  assign dout         = dout_q;
  assign sdram_req    = sdram_req_q;
  assign sdram_addr   = addr_q;
  assign sdram_rnw    = rnw_q;
  assign sdram_din    = din_q;
  assign sdram_wrmask = mask_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_jtframe_sdram_rrarb.sv
// Self-checking bench for jtframe_sdram_rrarb: directed scenarios plus a randomized
// run scored against a transaction-level arbitration model.
module tb_jtframe_sdram_rrarb;

  localparam int SDRAMW  = 22;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*SDRAMW-1:0] req_addr = '0;
  logic [NREQ-1:0]        req_wr = '0;
  logic [NREQ*16-1:0]     req_din = '0;
  logic [NREQ*2-1:0]      req_wrmask = '0;
  logic                   sdram_ack = 1'b0, data_rdy = 1'b0;
  logic [31:0]            data_read = '0;
  logic [NREQ-1:0]        gnt, rdy;
  logic [31:0]            dout;
  logic                   sdram_req, sdram_rnw, timeout;
  logic [SDRAMW-1:0]      sdram_addr;
  logic [15:0]            sdram_din;
  logic [1:0]             sdram_wrmask;

  logic [NREQ-1:0]        h_req = '0;
  logic                   h_ack = 1'b0, h_data_rdy = 1'b0;
  logic [NREQ-1:0]        h_gnt, h_rdy;
  logic [31:0]            h_dout;
  logic                   h_sdram_req, h_rnw, h_timeout;
  logic [SDRAMW-1:0]      h_addr;
  logic [15:0]            h_din;
  logic [1:0]             h_mask;

  int checks = 0;
  int failures = 0;

  // reference model state
  int                m_ptr = 0;
  logic [NREQ-1:0]   excl = '0;
  logic [SDRAMW-1:0] m_addr [NREQ];
  logic              m_wr   [NREQ];
  logic [15:0]       m_din  [NREQ];
  logic [1:0]        m_mask [NREQ];

  jtframe_sdram_rrarb #(.SDRAMW(SDRAMW), .NREQ(NREQ), .HIPRIO(4'b0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wr(req_wr),
    .req_din(req_din), .req_wrmask(req_wrmask), .gnt(gnt), .rdy(rdy), .dout(dout),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .sdram_rnw(sdram_rnw), .sdram_din(sdram_din), .sdram_wrmask(sdram_wrmask),
    .data_rdy(data_rdy), .data_read(data_read), .timeout(timeout)
  );

  jtframe_sdram_rrarb #(.SDRAMW(SDRAMW), .NREQ(NREQ), .HIPRIO(4'b0100), .TIMEOUT(TIMEOUT)) dut_hp (
    .clk(clk), .rst(rst), .req(h_req), .req_addr(req_addr), .req_wr(req_wr),
    .req_din(req_din), .req_wrmask(req_wrmask), .gnt(h_gnt), .rdy(h_rdy), .dout(h_dout),
    .sdram_req(h_sdram_req), .sdram_ack(h_ack), .sdram_addr(h_addr),
    .sdram_rnw(h_rnw), .sdram_din(h_din), .sdram_wrmask(h_mask),
    .data_rdy(h_data_rdy), .data_read(data_read), .timeout(h_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // arbitration rule: lowest pending high-priority index, else first pending at/after ptr
  function automatic int model_pick(input logic [NREQ-1:0] pend, input logic [NREQ-1:0] hip,
                                    input int ptr);
    for (int i = 0; i < NREQ; i++) if (pend[i] && hip[i]) return i;
    for (int k = 0; k < NREQ; k++) if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic new_request(input int i, input bit wr, input logic [SDRAMW-1:0] a,
                             input logic [15:0] d, input logic [1:0] mk);
    m_wr[i] = wr; m_addr[i] = a; m_din[i] = d; m_mask[i] = mk;
    req[i] = 1'b1; req_wr[i] = wr;
    req_addr[i*SDRAMW +: SDRAMW] = a;
    req_din[i*16 +: 16] = d;
    req_wrmask[i*2 +: 2] = mk;
  endtask

  task automatic new_random_request(input int i);
    new_request(i, 1'($urandom), SDRAMW'($urandom), 16'($urandom), 2'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; h_req = '0; sdram_ack = 1'b0; data_rdy = 1'b0;
    h_ack = 1'b0; h_data_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0; m_ptr = 0; excl = '0;
  endtask

  // one arbitration slot on the main DUT, followed by a full transaction if anything wins
  task automatic arb_cycle(input bit rnd, output int w);
    logic [NREQ-1:0] pend;
    logic [31:0]     rd_val;
    int              ad, rdl;
    bit              same;
    pend = req & ~excl;
    w = model_pick(pend, 4'b0000, m_ptr);
    tick();
    excl = '0;
    data_rdy = 1'b0;
    check("idle_rdy", rdy, 0);
    if (w < 0) begin
      check("idle_sreq", sdram_req, 0);
      check("idle_gnt", gnt, 0);
      return;
    end
    check("gnt", gnt, 1 << w);
    check("sreq", sdram_req, 1);
    check("addr", sdram_addr, m_addr[w]);
    check("rnw", sdram_rnw, !m_wr[w]);
    check("din", sdram_din, m_din[w]);
    check("mask", sdram_wrmask, m_mask[w]);
    if (rnd) begin
      req_addr[w*SDRAMW +: SDRAMW] = SDRAMW'($urandom);
      req_din[w*16 +: 16] = 16'($urandom);
    end
    ad = rnd ? $urandom_range(0, 3) : 0;
    for (int k = 0; k < ad; k++) begin
      data_rdy = rnd && ($urandom_range(0, 1) == 1);
      data_read = $urandom;
      if (rnd && $urandom_range(0, 4) == 0) req[w] = 1'b0;
      tick();
      data_rdy = 1'b0;
      check("wack_sreq", sdram_req, 1);
      check("wack_rdy", rdy, 0);
    end
    same = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
    rd_val = $urandom;
    sdram_ack = 1'b1; data_rdy = same; data_read = rd_val;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = $urandom;
    if (!same) begin
      check("ack_sreq", sdram_req, 0);
      check("ack_rdy", rdy, 0);
      rdl = rnd ? $urandom_range(0, 3) : 0;
      for (int k = 0; k < rdl; k++) begin
        tick();
        check("wrdy_rdy", rdy, 0);
        check("wrdy_gnt", gnt, 1 << w);
      end
      data_rdy = 1'b1; data_read = rd_val;
      tick();
      data_rdy = 1'b0;
    end
    check("rdy", rdy, 1 << w);
    check("dout", dout, rd_val);
    check("done_gnt", gnt, 0);
    check("done_sreq", sdram_req, 0);
    check("hold_addr", sdram_addr, m_addr[w]);
    m_ptr = (w + 1) % NREQ;
    excl = NREQ'(1 << w);
  endtask

  initial begin
    int w, pred, k;
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_rdy", rdy, 0);
    check("rst_dout", dout, 0);
    check("rst_sreq", sdram_req, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_rnw", sdram_rnw, 0);
    check("rst_timeout", timeout, 0);

    // single read
    new_request(0, 1'b0, 22'h001234, 16'h0000, 2'b00);
    tick();
    check("rd_sreq", sdram_req, 1);
    check("rd_addr", sdram_addr, 32'h1234);
    check("rd_rnw", sdram_rnw, 1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_rdy = 1'b1; data_read = 32'hDEADBEEF; req[0] = 1'b0;
    tick();
    data_rdy = 1'b0;
    check("rd_rdy", rdy, 4'b0001);
    check("rd_dout", dout, 32'hDEADBEEF);
    tick();
    check("rd_rdy_len", rdy, 0);

    // all four held: strict rotation
    do_reset();
    for (int i = 0; i < NREQ; i++) new_request(i, 1'b0, SDRAMW'(i * 16), 16'(i), 2'b00);
    for (int n = 0; n < 5; n++) arb_cycle(1'b0, w);
    req = '0;
    arb_cycle(1'b0, w);

    // write with ack and data_rdy in one cycle
    do_reset();
    new_request(1, 1'b1, 22'h0ABCDE, 16'hA5A5, 2'b10);
    tick();
    check("wr_rnw", sdram_rnw, 0);
    check("wr_mask", sdram_wrmask, 2'b10);
    check("wr_din", sdram_din, 16'hA5A5);
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h0BADF00D; req[1] = 1'b0;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    check("wr_rdy", rdy, 4'b0010);
    check("wr_sreq", sdram_req, 0);
    new_request(3, 1'b0, 22'h000033, 16'h0, 2'b00);
    tick();
    check("wr_idle_regrant", gnt, 4'b1000);
    req = '0;

    // reset abandons a transaction in WAIT_RDY
    do_reset();
    new_request(2, 1'b0, 22'h000222, 16'h0, 2'b00);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    check("mrst_gnt", gnt, 0);
    check("mrst_sreq", sdram_req, 0);
    check("mrst_rdy", rdy, 0);
    data_rdy = 1'b1; data_read = 32'h12345678;
    tick();
    data_rdy = 1'b0;
    check("mrst_late_rdy", rdy, 0);
    check("mrst_late_dout", dout, 0);

    // high-priority requester pre-empts the rotation
    do_reset();
    for (int i = 0; i < NREQ; i++) new_request(i, 1'b0, SDRAMW'(i + 5), 16'h0, 2'b00);
    req = '0;
    h_req = 4'b1011;
    pred = model_pick(h_req, 4'b0100, 0);
    tick();
    check("hp_first", h_gnt, 1 << pred);
    h_req[2] = 1'b1;
    h_ack = 1'b1;
    tick();
    h_ack = 1'b0;
    check("hp_ack_sreq", h_sdram_req, 0);
    h_data_rdy = 1'b1; data_read = 32'hCAFE0001; h_req[pred] = 1'b0;
    tick();
    h_data_rdy = 1'b0;
    check("hp_rdy1", h_rdy, 1 << pred);
    k = model_pick(h_req & ~(NREQ'(1 << pred)), 4'b0100, (pred + 1) % NREQ);
    tick();
    check("hp_preempt", h_gnt, 1 << k);
    check("hp_preempt_addr", h_addr, m_addr[k]);
    h_ack = 1'b1; h_data_rdy = 1'b1; h_req[k] = 1'b0;
    tick();
    h_ack = 1'b0; h_data_rdy = 1'b0;
    check("hp_rdy2", h_rdy, 1 << k);
    h_req = '0;

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 250; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) new_random_request(i);
      end
      data_rdy = ($urandom_range(0, 3) == 0);
      data_read = $urandom;
      arb_cycle(1'b1, w);
      if (w >= 0) begin
        if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
        else new_random_request(w);
      end
    end
    req = '0;
    arb_cycle(1'b1, w);
    arb_cycle(1'b1, w);
    check("timeout_low", timeout, 0);

`ifdef JTFRAME_ARB_TIMEOUT_EN
    do_reset();
    new_request(3, 1'b0, 22'h000777, 16'h0, 2'b00);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    k = 0;
    while (rdy == 0 && k < 4 * TIMEOUT) begin
      tick();
      k++;
    end
    req[3] = 1'b0;
    check("tmo_cycles", k, TIMEOUT);
    check("tmo_rdy", rdy, 4'b1000);
    check("tmo_dout", dout, 0);
    check("tmo_flag", timeout, 1);
    tick();
    check("tmo_sticky", timeout, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
